// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the gated-window frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_MAX_VAL = 99_999_999;

  // Gate window length in clk cycles; 10*CLK_HZ needs the full 34 bits.
  function automatic logic [33:0] gate_len(input logic [1:0] sel, input logic [33:0] clk_hz);
    logic [33:0] len;
    case (sel)
      2'd0:    len = clk_hz / 34'd100;
      2'd1:    len = clk_hz / 34'd10;
      2'd2:    len = clk_hz;
      default: len = clk_hz * 34'd10;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for an asynchronous input plus a one-cycle rising-edge pulse.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter_ctrl.sv
// Gated-window frequency counter: counts synchronised rising edges of sig_in over a
// selectable window and presents the last completed count to the display controller.
module freq_meter_ctrl
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned MAX_VAL     = DEFAULT_MAX_VAL,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_in,
  input  logic [1:0]  gate_sel,
  input  logic        hold,
  output logic [26:0] out_data,
  output logic        OutOfRange,
  output logic        meas_valid,
  output state_t      state_dbg
);

  // meas_valid is a one-cycle strobe with no back-pressure: out_data/OutOfRange change
  // only in the cycle it is high and are stable at all other times.

  localparam logic [26:0] MAX_CNT = 27'(MAX_VAL);
  localparam logic [33:0] CLK_HZ_W = 34'(CLK_HZ);

  state_t      state_q, state_d;
  logic [1:0]  sel_q;
  logic [33:0] gate_cnt;
  logic [33:0] gate_last;
  logic [26:0] edge_cnt;
  logic        ovf;
  logic        rise;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise)
  );

  assign gate_last = gate_len(sel_q, CLK_HZ_W) - 34'd1;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A gate_sel change takes priority over window completion: that window is discarded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = COUNT;
      COUNT: begin
        if (gate_sel != sel_q)         state_d = IDLE;
        else if (gate_cnt == gate_last) state_d = LATCH;
      end
      LATCH:   state_d = COUNT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q      <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
      out_data   <= '0;
      OutOfRange <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
          sel_q    <= gate_sel;
        end
        COUNT: begin
          gate_cnt <= gate_cnt + 34'd1;
          // Once ovf is set the counter parks at MAX_VAL+1 instead of wrapping.
          if (rise && !ovf) begin
            edge_cnt <= edge_cnt + 27'd1;
            if (edge_cnt == MAX_CNT) ovf <= 1'b1;
          end
        end
        LATCH: begin
          if (!hold) begin
            out_data   <= ovf ? MAX_CNT : edge_cnt;
            OutOfRange <= ovf;
            meas_valid <= 1'b1;
          end
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
          sel_q    <= gate_sel;
        end
        default: ;
      endcase
    end
  end

endmodule
